// File: rtl/vend_if.sv
// vend_if: coin, selection, dispenser and hopper signals of the vending controller; slave = controller side, master = driver side
interface vend_if #(parameter int CREDIT_W = 8);
  logic                coin_valid;
  logic [4:0]          coin_val;
  logic                coin_reject;
  logic                sel_valid;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_err;
  logic                cancel;
  logic                vend_req;
  logic                vend_ack;
  logic                chg_req;
  logic                chg_coin;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  modport slave (
    input  coin_valid, coin_val, sel_valid, sel_price, cancel, vend_ack, chg_ack,
    output coin_reject, sel_err, vend_req, chg_req, chg_coin, credit, busy
  );
  modport master (
    output coin_valid, coin_val, sel_valid, sel_price, cancel, vend_ack, chg_ack,
    input  coin_reject, sel_err, vend_req, chg_req, chg_coin, credit, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin credit accumulator, item vend handshake and dime-first change return (clk, async rst_n, vend_if.slave bus)
module vend_ctrl #(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100
) (
  input  logic   clk,
  input  logic   rst_n,
  vend_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx, chg_amt;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_reject, sel_err, coin_rej_nx, sel_err_nx;
  logic                open_st, cancel_act, sel_ok, sel_act, coin_ok, coin_act;
  always_comb begin
    open_st     = state == IDLE || state == COLLECT;
    cancel_act  = bus.cancel && state == COLLECT;
    sel_ok      = bus.sel_price != '0 && bus.sel_price % CREDIT_W'(5) == '0 && bus.sel_price <= credit;
    sel_act     = bus.sel_valid && state == COLLECT && sel_ok && !cancel_act;
    coin_sum    = {1'b0, credit} + (CREDIT_W+1)'(bus.coin_val);
    coin_ok     = (bus.coin_val == 5'd5 || bus.coin_val == 5'd10 || bus.coin_val == 5'd25)
                  && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    // cancel and an accepted selection both claim the cycle, so a coin alongside them is bounced
    coin_act    = bus.coin_valid && open_st && coin_ok && !cancel_act && !sel_act;
    coin_rej_nx = bus.coin_valid && !coin_act;
    sel_err_nx  = bus.sel_valid && !sel_act;
    chg_amt     = credit >= CREDIT_W'(10) ? CREDIT_W'(10) : CREDIT_W'(5);
    state_nx    = state;
    credit_nx   = credit;
    if (coin_act) begin
      credit_nx = coin_sum[CREDIT_W-1:0];
      state_nx  = COLLECT;
    end
    if (cancel_act) state_nx = CHANGE;
    if (sel_act) begin
      credit_nx = credit - bus.sel_price;
      state_nx  = VEND;
    end
    if (state == VEND && bus.vend_ack) state_nx = credit != '0 ? CHANGE : IDLE;
    if (state == CHANGE && bus.chg_ack) begin
      credit_nx = credit - chg_amt;
      state_nx  = credit_nx == '0 ? IDLE : CHANGE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      coin_reject <= coin_rej_nx;
      sel_err     <= sel_err_nx;
    end
  assign bus.credit      = credit;
  assign bus.coin_reject = coin_reject;
  assign bus.sel_err     = sel_err;
  assign bus.vend_req    = state == VEND;
  assign bus.chg_req     = state == CHANGE;
  assign bus.chg_coin    = state == CHANGE && credit >= CREDIT_W'(10);
  assign bus.busy        = state == VEND || state == CHANGE;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed checks of vend_ctrl credit, vend, change and reset behaviour
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  vend_if #(.CREDIT_W(8)) bus ();
  vend_ctrl #(.CREDIT_W(8), .MAX_CREDIT(100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [4:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_val   = v;
    tick();
    bus.coin_valid = 1'b0;
  endtask
  task automatic sel(input logic [7:0] p);
    bus.sel_valid = 1'b1;
    bus.sel_price = p;
    tick();
    bus.sel_valid = 1'b0;
  endtask
  initial begin
    int dimes, nickels;
    bus.coin_valid = 0; bus.coin_val = 0; bus.sel_valid = 0; bus.sel_price = 0;
    bus.cancel = 0; bus.vend_ack = 0; bus.chg_ack = 0;
    #12 rst_n = 1'b1;
    tick();
    check("rst_credit", bus.credit, 0);
    check("rst_outs", {bus.coin_reject, bus.sel_err, bus.vend_req, bus.chg_req, bus.chg_coin, bus.busy}, 0);
    bus.vend_ack = 1; tick(); bus.vend_ack = 0;
    check("idle_vend_ack", {bus.busy, bus.vend_req}, 0);
    coin(25); check("c25", bus.credit, 25); check("c25_rej", bus.coin_reject, 0);
    coin(25); check("c50", bus.credit, 50);
    coin(10); check("c60", bus.credit, 60); check("c60_rej", bus.coin_reject, 0);
    sel(45);
    check("sel45_credit", bus.credit, 15);
    check("sel45_vreq", {bus.vend_req, bus.busy, bus.sel_err}, 3'b110);
    tick(); tick();
    check("vreq_hold", bus.vend_req, 1);
    bus.vend_ack = 1; tick(); bus.vend_ack = 0;
    check("vend_done", {bus.vend_req, bus.chg_req, bus.chg_coin}, 3'b011);
    bus.chg_ack = 1; tick();
    check("chg1", {bus.chg_req, bus.chg_coin}, 2'b10); check("chg1_credit", bus.credit, 5);
    tick(); bus.chg_ack = 0;
    check("chg2", {bus.chg_req, bus.busy}, 0); check("chg2_credit", bus.credit, 0);
    coin(25); coin(25); coin(25); coin(10); coin(5);
    check("c90", bus.credit, 90);
    coin(25);
    check("over_rej", bus.coin_reject, 1); check("over_credit", bus.credit, 90);
    tick(); check("rej_pulse", bus.coin_reject, 0);
    coin(10); check("c100", bus.credit, 100); check("c100_rej", bus.coin_reject, 0);
    coin(7); check("bad_coin", bus.coin_reject, 1); check("bad_credit", bus.credit, 100);
    bus.cancel = 1; tick(); bus.cancel = 0;
    dimes = 0; nickels = 0;
    bus.chg_ack = 1;
    for (int i = 0; i < 40 && bus.chg_req; i++) begin
      if (bus.chg_coin) dimes++; else nickels++;
      tick();
    end
    bus.chg_ack = 0;
    check("r100_dimes", dimes, 10); check("r100_nickels", nickels, 0);
    check("r100_end", {bus.busy, bus.credit}, 0);
    coin(10); coin(10);
    sel(35); check("sel35_err", bus.sel_err, 1); check("sel35_credit", bus.credit, 20);
    sel(12); check("sel12_err", bus.sel_err, 1); check("sel12_busy", bus.busy, 0);
    sel(0);  check("sel0_err", bus.sel_err, 1);
    sel(20); check("sel20", {bus.vend_req, bus.sel_err}, 2'b10); check("sel20_credit", bus.credit, 0);
    bus.vend_ack = 1; tick(); bus.vend_ack = 0;
    check("sel20_idle", {bus.busy, bus.chg_req}, 0);
    coin(25); coin(10);
    bus.cancel = 1; tick(); bus.cancel = 0;
    check("can_start", {bus.chg_req, bus.chg_coin, bus.busy}, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("can_hold", {bus.chg_req, bus.chg_coin, bus.credit}, {2'b11, 8'd35});
    end
    bus.chg_ack = 1; tick(); bus.chg_ack = 0;
    check("r35_1", {bus.chg_req, bus.chg_coin, bus.credit}, {2'b11, 8'd25});
    tick();
    bus.chg_ack = 1; tick(); bus.chg_ack = 0;
    check("r35_2", {bus.chg_req, bus.chg_coin, bus.credit}, {2'b11, 8'd15});
    bus.chg_ack = 1; tick(); bus.chg_ack = 0;
    check("r35_3", {bus.chg_req, bus.chg_coin, bus.credit}, {2'b10, 8'd5});
    bus.chg_ack = 1; tick(); bus.chg_ack = 0;
    check("r35_4", {bus.chg_req, bus.busy, bus.credit}, 0);
    coin(10);
    bus.sel_valid = 1; bus.sel_price = 10; bus.coin_valid = 1; bus.coin_val = 5;
    tick();
    bus.sel_valid = 0; bus.coin_valid = 0;
    check("same_cyc", {bus.vend_req, bus.coin_reject, bus.sel_err}, 3'b110);
    check("same_credit", bus.credit, 0);
    coin(5); check("vend_coin_rej", bus.coin_reject, 1); check("vend_coin_credit", bus.credit, 0);
    bus.cancel = 1; tick(); bus.cancel = 0;
    check("vend_cancel_ign", {bus.vend_req, bus.chg_req}, 2'b10);
    bus.vend_ack = 1; tick(); bus.vend_ack = 0;
    check("same_idle", {bus.busy, bus.chg_req}, 0);
    coin(10); coin(5);
    bus.cancel = 1; tick(); bus.cancel = 0;
    check("rst_pre", {bus.chg_req, bus.credit}, {1'b1, 8'd15});
    #2 rst_n = 1'b0;
    #1;
    check("async_outs", {bus.coin_reject, bus.sel_err, bus.vend_req, bus.chg_req, bus.chg_coin, bus.busy}, 0);
    check("async_credit", bus.credit, 0);
    #2 rst_n = 1'b1;
    tick();
    bus.chg_ack = 1; tick(); bus.chg_ack = 0;
    check("post_rst", {bus.chg_req, bus.busy, bus.credit}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Transaction controller for the coin-operated vending datapath.
- Accepts 5/10/25-cent coins and accumulates credit.
- Takes an item selection with a price and sequences the item dispenser through a req/ack handshake.
- Returns change or a cancel refund coin-by-coin (dimes first, then nickels) through a second req/ack handshake to the coin hopper.

Parameters:
- CREDIT_W, 8, width of the credit register and of sel_price.
- MAX_CREDIT, 100, maximum credit in cents; must be a multiple of 5 and less than 2**CREDIT_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  coin present this cycle, single-cycle strobe.
- coin_val  in  5  coin value in cents; only 5, 10, 25 are legal.
- coin_reject  out  1  one-cycle pulse, registered, the cycle after a rejected coin_valid.
- sel_valid  in  1  item selection strobe.
- sel_price  in  CREDIT_W  price of the selected item in cents.
- sel_err  out  1  one-cycle pulse, registered, the cycle after a refused selection.
- cancel  in  1  refund request strobe.
- vend_req  out  1  dispense-item request, held until vend_ack.
- vend_ack  in  1  dispenser done.
- chg_req  out  1  return-one-coin request, held until chg_ack.
- chg_coin  out  1  coin to return (0 = 5c, 1 = 10c); stable while chg_req = 1.
- chg_ack  in  1  hopper released the coin.
- credit  out  CREDIT_W  current credit, registered.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (rst_n low, async): state IDLE, credit 0. All outputs 0: coin_reject, sel_err, vend_req, chg_req, chg_coin, busy.
- Reset mid-transaction aborts it immediately; outstanding credit is discarded; no change is issued.
- States and transitions:
  - IDLE (credit = 0) -> COLLECT on an accepted coin.
  - COLLECT -> VEND on an accepted selection.
  - COLLECT -> CHANGE on cancel.
  - VEND -> CHANGE on vend_ack if credit > 0, else -> IDLE.
  - CHANGE -> IDLE on the chg_ack that brings credit to 0.
- Per-cycle input priority in IDLE/COLLECT: cancel > sel_valid > coin_valid.
  - A coin_valid in the same cycle as an acted-on cancel or sel_valid is rejected (coin_reject pulses).
  - A refused selection does not block a coin in the same cycle.
- Coin acceptance: coin_val must be in {5, 10, 25}, state must be IDLE/COLLECT, and credit + coin_val ≤ MAX_CREDIT. Otherwise the coin is rejected.
  - Accepted coin: credit updates the next cycle.
- Selection acceptance (COLLECT only): sel_price ≠ 0, sel_price a multiple of 5, and sel_price ≤ credit.
  - Accepted: credit ← credit − sel_price; vend_req rises the next cycle.
  - Otherwise: sel_err pulses and state and credit are unchanged.
  - sel_valid in IDLE, VEND or CHANGE: sel_err pulses.
- cancel in IDLE, VEND or CHANGE is ignored.
- VEND: vend_req stays high until a cycle with vend_ack = 1; it deasserts the following cycle.
  - vend_ack while vend_req = 0 is ignored.
- CHANGE, per coin: chg_coin = 1 if credit ≥ 10, else 0; chg_req = 1.
  - On chg_ack, credit decreases by 10 or 5 accordingly.
  - On the next cycle, chg_req stays high with the recomputed chg_coin if credit > 0 (back-to-back allowed); otherwise it drops and the FSM enters IDLE.
  - chg_ack while chg_req = 0 is ignored.
- busy = 1 exactly in VEND and CHANGE.
- credit never exceeds MAX_CREDIT and never underflows. It stays a multiple of 5 at all times.

Test Plan:
- Reset then coins 25, 25, 10 → credit 25, 50, 60; no coin_reject. Select price 45 → credit 15, vend_req high until ack. After vend_ack → chg_req with chg_coin = 1, ack → chg_coin = 0, ack → chg_req = 0, IDLE, credit 0.
- Credit 90 plus coin 25 → coin_reject pulse, credit stays 90. Coin 10 → credit 100. Illegal coin_val = 7 → coin_reject.
- Credit 20: select price 35 → sel_err, credit 20. Select price 12 → sel_err. Select price 20 → vend, then IDLE with no chg_req.
- Credit 35 then cancel → refunds 10, 10, 10, 5 in that order, one per chg_ack; chg_ack held low for 3 cycles keeps chg_req/chg_coin stable.
- Same-cycle sel_valid (price 10) and coin_valid (5) at credit 10 → vend accepted, coin_reject pulse, credit 0. Coin during VEND → coin_reject.
- rst_n asserted asynchronously mid-CHANGE with credit 15 → all outputs 0 immediately, credit 0, IDLE after release; spurious chg_ack afterwards is ignored.
